// File: rtl/fc_per2apb_pkg.sv
// Shared types and constants for the per-bus to APB bridge.
//   state_e   : bridge FSM states
//   OPC_OK/ERR: per-bus response opcodes
//   BE_FULL   : only full-word writes are forwarded to APB
//   cnt_width : width of a counter that must hold 0..n (at least 1 bit)
package fc_per2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fc_apb_timeout_cnt.sv
// PREADY watchdog for the APB ACCESS phase.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : restart the count (asserted when a transfer enters SETUP)
//   en_i          : an ACCESS cycle passed without pready
//   expired_o     : this enabled cycle is the TIMEOUT_CYCLES-th one without pready
// The count saturates at TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables the watchdog.
module fc_apb_timeout_cnt
  import fc_per2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, clr_i, en_i};
    assign expired_o   = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    // Expire in the cycle whose increment would reach the limit, so the
    // transfer leaves ACCESS after exactly TIMEOUT_CYCLES stalled cycles.
    assign expired_o = en_i && (cnt_q >= LAST);
  end

endmodule

// File: rtl/fc_per2apb_bridge.sv
// Per-bus slave to APB master bridge, one outstanding transaction.
// A per-bus initiator reaches an APB slave through a single SETUP/ACCESS
// transfer; a PREADY watchdog bounds how long a silent slave can stall it.
//   clk_i, rst_ni            : clock, async active-low reset
//   per_slave_req_i/gnt_o    : request / combinational grant (IDLE only)
//   per_slave_add_i/we_i/be_i/wdata_i/id_i : request payload
//   per_slave_r_valid_o      : one-cycle response pulse (writes included)
//   per_slave_r_opc_o/rdata_o/id_o : response opcode, read data, echoed id
//   paddr_o/pwdata_o/pwrite_o/psel_o/penable_o : APB master request
//   prdata_i/pready_i/pslverr_i : APB slave response
//
// state  | meaning
// IDLE   | waiting for a request; gnt follows req
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready or watchdog expiry
// RESP   | per-bus response pulse, no grant
module fc_per2apb_bridge
  import fc_per2apb_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  output logic                      per_slave_gnt_o,
  input  logic [31:0]               per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  state_e                    state_q, state_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      r_valid_q, r_valid_d;
  logic                      r_opc_q, r_opc_d;
  logic [31:0]               r_rdata_q, r_rdata_d;
  logic [ID_WIDTH-1:0]       r_id_q, r_id_d;
  logic                      gnt;
  logic                      wd_clr, wd_en, wd_expired;
  logic [APB_ADDR_WIDTH-1:0] paddr_aligned;

  // APB is word-addressed here: keep the per address LSBs, force byte offset to 0.
  assign paddr_aligned = APB_ADDR_WIDTH'(per_slave_add_i) & ~APB_ADDR_WIDTH'(3);

  fc_apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) i_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    r_valid_d = 1'b0;
    r_opc_d   = r_opc_q;
    r_rdata_d = r_rdata_q;
    r_id_d    = r_id_q;
    gnt       = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = per_slave_req_i;
        if (per_slave_req_i) begin
          r_id_d = per_slave_id_i;
          if (per_slave_we_i && (per_slave_be_i != BE_FULL)) begin
            // Sub-word writes cannot be expressed on this APB: refuse them.
            state_d   = RESP;
            r_valid_d = 1'b1;
            r_opc_d   = OPC_ERR;
            r_rdata_d = '0;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = paddr_aligned;
            pwrite_d = per_slave_we_i;
            pwdata_d = per_slave_wdata_i;
            wd_clr   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        wd_en = !pready_i;
        // pready is evaluated first so a reply in the expiry cycle still completes normally.
        if (pready_i) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_valid_d = 1'b1;
          r_opc_d   = pslverr_i;
          r_rdata_d = pwrite_q ? 32'h0 : prdata_i;
        end else if (wd_expired) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_valid_d = 1'b1;
          r_opc_d   = OPC_ERR;
          r_rdata_d = '0;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      r_valid_q <= 1'b0;
      r_opc_q   <= OPC_OK;
      r_rdata_q <= '0;
      r_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      r_valid_q <= r_valid_d;
      r_opc_q   <= r_opc_d;
      r_rdata_q <= r_rdata_d;
      r_id_q    <= r_id_d;
    end
  end

  assign per_slave_gnt_o     = gnt;
  assign per_slave_r_valid_o = r_valid_q;
  assign per_slave_r_opc_o   = r_opc_q;
  assign per_slave_r_rdata_o = r_rdata_q;
  assign per_slave_r_id_o    = r_id_q;
  assign paddr_o             = paddr_q;
  assign pwdata_o            = pwdata_q;
  assign pwrite_o            = pwrite_q;
  assign psel_o              = psel_q;
  assign penable_o           = penable_q;

endmodule

// File: tb/tb_fc_per2apb_bridge.sv
module tb_fc_per2apb_bridge;

  localparam int TO = 4;

  typedef struct {
    logic        opc;
    logic [31:0] rdata;
    logic [7:0]  id;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  id;
  logic        r_valid;
  logic        r_opc;
  logic [31:0] r_rdata;
  logic [7:0]  r_id;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  fc_per2apb_bridge #(
    .ID_WIDTH      (8),
    .APB_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .per_slave_req_i    (req),
    .per_slave_gnt_o    (gnt),
    .per_slave_add_i    (add),
    .per_slave_we_i     (we),
    .per_slave_be_i     (be),
    .per_slave_wdata_i  (wdata),
    .per_slave_id_i     (id),
    .per_slave_r_valid_o(r_valid),
    .per_slave_r_opc_o  (r_opc),
    .per_slave_r_rdata_o(r_rdata),
    .per_slave_r_id_o   (r_id),
    .paddr_o            (paddr),
    .pwdata_o           (pwdata),
    .pwrite_o           (pwrite),
    .psel_o             (psel),
    .penable_o          (penable),
    .prdata_i           (prdata),
    .pready_i           (pready),
    .pslverr_i          (pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response scoreboard: every r_valid pulse must match the oldest expectation,
  // including the cycle it was predicted for.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && r_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_r_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("r_opc", r_opc, mon_e.opc);
        chk("r_rdata", r_rdata, mon_e.rdata);
        chk("r_id", r_id, mon_e.id);
        chk("r_valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the RESP cycle.
  task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic [31:0] wd, input logic [7:0] tid, input int waits,
                     input logic [31:0] rd, input logic err, input bit to);
    bit          rej;
    int          nacc;
    int          lat;
    exp_t        e;
    logic [31:0] exp_paddr;
    rej       = w && (b != 4'hF);
    nacc      = to ? TO : waits + 1;
    lat       = rej ? 1 : 2 + nacc;
    exp_paddr = a & 32'hFFFF_FFFC;
    req = 1'b1; add = a; we = w; be = b; wdata = wd; id = tid;
    #1;
    chk("gnt_idle", gnt, 1'b1);
    e.opc   = (rej || to) ? 1'b1 : err;
    e.rdata = (rej || to || w) ? 32'h0 : rd;
    e.id    = tid;
    e.cyc   = cyc + lat;
    sb_q.push_back(e);
    @(negedge clk);
    // Request payload is scrambled to prove the bridge latched it.
    req = 1'b0; add = $urandom; wdata = $urandom; id = 8'($urandom); we = ~w;
    chk("gnt_after_accept", gnt, 1'b0);
    if (rej) begin
      chk("rej_psel", psel, 1'b0);
      chk("rej_penable", penable, 1'b0);
      return;
    end
    chk("setup_psel", psel, 1'b1);
    chk("setup_penable", penable, 1'b0);
    chk("setup_paddr", paddr, exp_paddr);
    chk("setup_pwrite", pwrite, w);
    if (w) chk("setup_pwdata", pwdata, wd);
    prdata = rd;
    for (int i = 0; i < nacc; i++) begin
      @(negedge clk);
      chk("access_psel", psel, 1'b1);
      chk("access_penable", penable, 1'b1);
      chk("access_paddr", paddr, exp_paddr);
      chk("access_pwrite", pwrite, w);
      if (w) chk("access_pwdata", pwdata, wd);
      if (!to && i == waits) begin
        pready = 1'b1; pslverr = err;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
    end
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    chk("resp_psel", psel, 1'b0);
    chk("resp_penable", penable, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; add = '0; we = 1'b0; be = 4'h0; wdata = '0; id = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_opc", r_opc, 1'b0);
    chk("rst_r_rdata", r_rdata, 32'h0);
    chk("rst_r_id", r_id, 8'h0);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait read.
    txn(32'h1A10_0008, 1'b0, 4'hF, 32'h0, 8'd5, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
    @(negedge clk);
    // Full write, 3 wait states (pready lands in the watchdog's last cycle).
    txn(32'h1A10_0104, 1'b1, 4'hF, 32'h1234_5678, 8'h21, 3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    // Partial write is refused.
    txn(32'h1A10_0200, 1'b1, 4'h3, 32'hAAAA_5555, 8'h33, 0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    // Read with slave error.
    txn(32'h1A10_0300, 1'b0, 4'hF, 32'h0, 8'h44, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(negedge clk);
    // Hung slave: watchdog.
    txn(32'h1A10_0400, 1'b0, 4'hF, 32'h0, 8'h55, 0, 32'h5A5A_A5A5, 1'b0, 1'b1);
    @(negedge clk);
    // Normal read after timeout, unaligned address, byte enables ignored.
    txn(32'h0000_0013, 1'b0, 4'h0, 32'h0, 8'h66, 2, 32'h0BAD_CAFE, 1'b0, 1'b0);
    // Request held through RESP: no grant there, granted next cycle.
    req = 1'b1; add = 32'h1A10_0500; we = 1'b1; be = 4'hF; wdata = 32'h0F0F_F0F0; id = 8'h77;
    #1;
    chk("gnt_in_resp", gnt, 1'b0);
    @(negedge clk);
    txn(32'h1A10_0500, 1'b1, 4'hF, 32'h0F0F_F0F0, 8'h77, 0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    // Write with slave error.
    txn(32'h1A10_0600, 1'b1, 4'hF, 32'h1111_2222, 8'h88, 1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset in the middle of ACCESS: bus drops at once, no response.
    req = 1'b1; add = 32'h1A10_0700; we = 1'b0; be = 4'hF; id = 8'h99;
    #1;
    chk("gnt_pre_reset", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("pre_reset_penable", penable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel", psel, 1'b0);
    chk("async_rst_penable", penable, 1'b0);
    chk("async_rst_r_valid", r_valid, 1'b0);
    @(negedge clk);
    chk("rst_hold_r_opc", r_opc, 1'b0);
    chk("rst_hold_r_id", r_id, 8'h0);
    chk("rst_hold_paddr", paddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    txn(32'h1A10_0804, 1'b0, 4'hF, 32'h0, 8'hAB, 0, 32'h7654_3210, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
